tt_result_uart_tx: RTL and testbench

//   Serial transmitter for 8-bit datapath results (e.g. sum/AND output Y).

---
 rtl/tt_result_uart_tx.sv | 203 ++++++++++++++++++++
 tb/tb_tt_result_uart_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_result_uart_tx.sv
// ---------------------------------------------------------------------------
// tt_result_uart_tx
//   Serial transmitter for 8-bit datapath results. A byte is taken over a
//   valid/ready handshake and shifted out on a single pin as an async frame:
//   start bit (0), eight data bits LSB first, optional even parity bit and
//   one or two stop bits (1). The line idles high.
//
//   Frame length is FRAME = (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT.
//   The final cycle of the last stop bit is spent back in IDLE with ready=1
//   and done=1. A producer holding valid high is therefore accepted on the
//   edge that ends the frame, and the next start bit follows the stop bit
//   with no gap, giving one accept every FRAME cycles.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   PARITY_EN     1 = append even-parity bit after the data bits
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   reset    in   asynchronous active-high reset, aborts any frame at once
//   data_in  in   byte to send, sampled only on the accepting edge
//   valid    in   producer has data_in available
//   ready    out  transmitter idle, a valid this cycle is accepted
//   tx       out  serial line, idle high
//   busy     out  frame in progress (complement of ready outside reset)
//   done     out  one-cycle pulse in the final cycle of a frame
// ---------------------------------------------------------------------------
module tt_result_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO   = '0;
    localparam logic [2:0]        STOP_LAST   = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q,  baud_d;
    logic [2:0]        bit_q,   bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q,   par_d;
    logic              tx_q,    tx_d;
    logic              ready_q, ready_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic              baud_wrap;

    assign baud_wrap = (baud_q == BAUD_LAST);

    // Next-state and registered-output logic. tx_d always holds the line
    // level for the cycle after the coming edge, so tx is a pure flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (valid && ready_q) begin
                    state_d = ST_START;
                    baud_d  = BAUD_ZERO;
                    bit_d   = 3'd0;
                    shift_d = data_in;
                    par_d   = ^data_in;
                    tx_d    = 1'b0;
                end
            end

            ST_START: begin
                if (baud_wrap) begin
                    state_d = ST_DATA;
                    baud_d  = BAUD_ZERO;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            ST_DATA: begin
                if (baud_wrap) begin
                    baud_d  = BAUD_ZERO;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        // shift_q[0] is on the line now, [1] goes next
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            ST_PARITY: begin
                if (baud_wrap) begin
                    state_d = ST_STOP;
                    baud_d  = BAUD_ZERO;
                    bit_d   = 3'd0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            ST_STOP: begin
                tx_d = 1'b1;
                // Leave one cycle early: the last stop-bit cycle is spent
                // in IDLE so a waiting producer is accepted without a gap.
                if ((bit_q == STOP_LAST) && (baud_q == BAUD_PENULT)) begin
                    state_d = ST_IDLE;
                    baud_d  = BAUD_ZERO;
                    bit_d   = 3'd0;
                    done_d  = 1'b1;
                end else if (baud_wrap) begin
                    baud_d = BAUD_ZERO;
                    bit_d  = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = BAUD_ZERO;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Control state and outputs; reset forces the idle line immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= BAUD_ZERO;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Payload holding registers; only meaningful once a byte is accepted.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_tt_result_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_tt_result_uart_tx
//   Four transmitter instances with different parameter sets share one clock:
//     0: CLKS_PER_BIT=4, no parity, 1 stop
//     1: CLKS_PER_BIT=4, parity,    1 stop
//     2: CLKS_PER_BIT=4, no parity, 2 stop
//     3: CLKS_PER_BIT=2, no parity, 1 stop
//   Cycle numbering: t=0 is the first cycle after the accepting edge, so the
//   handshake cycle is "cycle 0" of the spec's counting and done shows at
//   t = FRAME-1, i.e. FRAME cycles after the handshake cycle.
// ---------------------------------------------------------------------------
module tb_tt_result_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_v [4];
    logic       valid_v [4];
    logic [7:0] data_v  [4];
    logic       ready_v [4];
    logic       tx_v    [4];
    logic       busy_v  [4];
    logic       done_v  [4];

    int n_checks = 0;
    int n_fail   = 0;

    logic cap_tx    [0:127];
    logic cap_done  [0:127];
    logic cap_busy  [0:127];
    logic cap_ready [0:127];

    tt_result_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset_v[0]), .data_in(data_v[0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    tt_result_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset_v[1]), .data_in(data_v[1]), .valid(valid_v[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    tt_result_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset_v[2]), .data_in(data_v[2]), .valid(valid_v[2]),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    tt_result_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(1)) u_dut3 (
        .clk(clk), .reset(reset_v[3]), .data_in(data_v[3]), .valid(valid_v[3]),
        .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    // ---------------- reference model ----------------
    function automatic int cpb(int k);
        return (k == 3) ? 2 : 4;
    endfunction
    function automatic int par(int k);
        return (k == 1) ? 1 : 0;
    endfunction
    function automatic int stp(int k);
        return (k == 2) ? 2 : 1;
    endfunction
    function automatic int frame_len(int k);
        return (9 + par(k) + stp(k)) * cpb(k);
    endfunction

    // Level of serial bit number idx of a frame carrying b.
    function automatic logic frame_bit(logic [7:0] b, int p, int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (p != 0 && idx == 9) return (($countones(b) % 2) == 1);
        return 1'b1;
    endfunction

    // Line level at cycle t for nf (1 or 2) consecutive frames b0, b1.
    function automatic logic exp_tx(int k, logic [7:0] b0, logic [7:0] b1, int nf, int t);
        int f;
        f = frame_len(k);
        if (t < f) return frame_bit(b0, par(k), t / cpb(k));
        if (nf == 2 && t < 2 * f) return frame_bit(b1, par(k), (t - f) / cpb(k));
        return 1'b1;
    endfunction

    function automatic logic exp_done(int k, int nf, int t);
        int f;
        f = frame_len(k);
        return (t == f - 1) || (nf == 2 && t == 2 * f - 1);
    endfunction

    function automatic logic exp_busy(int k, int nf, int t);
        int f;
        f = frame_len(k);
        return (t < f - 1) || (nf == 2 && t >= f && t < 2 * f - 1);
    endfunction

    // Recover a byte from the captured line by mid-bit sampling.
    function automatic logic [7:0] decode(int k, int base);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[i] = cap_tx[base + (1 + i) * cpb(k) + cpb(k) / 2];
        return r;
    endfunction

    // ---------------- stimulus / capture ----------------
    // Offers b0, waits (bounded) for the accept, then records ncyc cycles.
    // data_in is changed to b1 after the accept. valid stays high through the
    // accept following cycle hold_until (hold_until < 0: dropped at once).
    // At t == pulse_t valid is pulsed for one edge with data 8'hFF.
    task automatic send_capture(input int k, input logic [7:0] b0, input logic [7:0] b1,
                                input int ncyc, input int hold_until, input int pulse_t,
                                output bit ok);
        int w;
        ok = 1'b1;
        w  = 0;
        @(negedge clk);
        valid_v[k] = 1'b1;
        data_v[k]  = b0;
        while (ready_v[k] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            ok = 1'b0;
            valid_v[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        data_v[k] = b1;
        if (hold_until < 0) valid_v[k] = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            cap_tx[t]    = tx_v[k];
            cap_done[t]  = done_v[k];
            cap_busy[t]  = busy_v[k];
            cap_ready[t] = ready_v[k];
            if (t == hold_until + 1) valid_v[k] = 1'b0;
            if (t == pulse_t) begin
                valid_v[k] = 1'b1;
                data_v[k]  = 8'hFF;
            end else if (t == pulse_t + 1) begin
                valid_v[k] = 1'b0;
                data_v[k]  = b1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] b;
        int w;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({tx_v[k], ready_v[k], busy_v[k], done_v[k]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_hold dut%0d tx/ready/busy/done got %b%b%b%b exp 1100",
                         k, tx_v[k], ready_v[k], busy_v[k], done_v[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) reset_v[k] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({tx_v[k], ready_v[k], busy_v[k], done_v[k]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_release dut%0d tx/ready/busy/done got %b%b%b%b exp 1100",
                         k, tx_v[k], ready_v[k], busy_v[k], done_v[k]);
            end
        end

        // Abort a frame while a zero data bit is on the line.
        b = 8'($urandom) & 8'hFB;
        w = 0;
        @(negedge clk);
        valid_v[0] = 1'b1;
        data_v[0]  = b;
        while (ready_v[0] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++;
        if (tx_v[0] !== exp_tx(0, b, 8'h00, 1, 13) || busy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preabort tx/busy got %b/%b exp %b/1",
                     tx_v[0], busy_v[0], exp_tx(0, b, 8'h00, 1, 13));
        end
        #1;
        reset_v[0] = 1'b1;
        #1;
        n_checks++;
        if ({tx_v[0], ready_v[0], busy_v[0], done_v[0]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_abort tx/ready/busy/done got %b%b%b%b exp 1100",
                     tx_v[0], ready_v[0], busy_v[0], done_v[0]);
        end
        repeat (2) @(negedge clk);
        #1;
        reset_v[0] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_v[0], ready_v[0], busy_v[0], done_v[0]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_idle t=%0d tx/ready/busy/done got %b%b%b%b exp 1100",
                         t, tx_v[0], ready_v[0], busy_v[0], done_v[0]);
            end
        end
    endtask

    // Single frames on instances 0/1/2 (basic, parity, two stop bits).
    task automatic test_frames(input int k, input logic [7:0] first, input logic [7:0] second);
        logic [7:0] b;
        bit ok;
        int f;
        f = frame_len(k);
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? first : (n == 1) ? second : 8'($urandom);
            send_capture(k, b, 8'($urandom), f + 6, -1, -10, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL frame_accept dut%0d byte=%02h got no accept exp accept", k, b);
                continue;
            end
            for (int t = 0; t < f + 6; t++) begin
                n_checks++;
                if (cap_tx[t] !== exp_tx(k, b, 8'h00, 1, t)) begin
                    n_fail++;
                    $display("FAIL frame_tx dut%0d byte=%02h t=%0d got %b exp %b",
                             k, b, t, cap_tx[t], exp_tx(k, b, 8'h00, 1, t));
                end
                n_checks++;
                if (cap_done[t] !== exp_done(k, 1, t)) begin
                    n_fail++;
                    $display("FAIL frame_done dut%0d byte=%02h t=%0d got %b exp %b",
                             k, b, t, cap_done[t], exp_done(k, 1, t));
                end
                n_checks++;
                if ({cap_busy[t], cap_ready[t]} !== {exp_busy(k, 1, t), !exp_busy(k, 1, t)}) begin
                    n_fail++;
                    $display("FAIL frame_busy dut%0d byte=%02h t=%0d busy/ready got %b%b exp %b%b",
                             k, b, t, cap_busy[t], cap_ready[t],
                             exp_busy(k, 1, t), !exp_busy(k, 1, t));
                end
            end
        end
    endtask

    // Directed 0xA5 pattern: start, data LSB-first, stop = 0,1,0,1,0,0,1,0,1,1.
    task automatic test_a5_pattern(input int k);
        logic [9:0] pat;
        logic [9:0] got;
        bit ok;
        pat = 10'b1101001010;
        got = '0;
        send_capture(k, 8'hA5, 8'h5A, frame_len(k) + 4, -1, -10, ok);
        for (int i = 0; i < 10; i++) got[i] = cap_tx[i * cpb(k) + cpb(k) / 2];
        n_checks++;
        if (!ok || got !== pat) begin
            n_fail++;
            $display("FAIL a5_pattern dut%0d got %b exp %b", k, got, pat);
        end
        n_checks++;
        if (cap_done[frame_len(k) - 1] !== 1'b1 || cap_done[frame_len(k) - 2] !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_done_time dut%0d got %b%b exp 10", k,
                     cap_done[frame_len(k) - 1], cap_done[frame_len(k) - 2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0;
        logic [7:0] b1;
        bit ok;
        int f;
        f = frame_len(0);
        for (int n = 0; n < 2; n++) begin
            b0 = (n == 0) ? 8'h3C : 8'($urandom);
            b1 = (n == 0) ? 8'hC3 : 8'($urandom);
            send_capture(0, b0, b1, 2 * f + 6, f - 1, -10, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b2b_accept got no accept exp accept");
                continue;
            end
            for (int t = 0; t < 2 * f + 6; t++) begin
                n_checks++;
                if (cap_tx[t] !== exp_tx(0, b0, b1, 2, t) || cap_done[t] !== exp_done(0, 2, t) ||
                    cap_busy[t] !== exp_busy(0, 2, t) || cap_ready[t] !== !exp_busy(0, 2, t)) begin
                    n_fail++;
                    $display("FAIL b2b t=%0d tx/done/busy/ready got %b%b%b%b exp %b%b%b%b", t,
                             cap_tx[t], cap_done[t], cap_busy[t], cap_ready[t],
                             exp_tx(0, b0, b1, 2, t), exp_done(0, 2, t),
                             exp_busy(0, 2, t), !exp_busy(0, 2, t));
                end
            end
            n_checks++;
            if (decode(0, 0) !== b0 || decode(0, f) !== b1) begin
                n_fail++;
                $display("FAIL b2b_decode got %02h %02h exp %02h %02h",
                         decode(0, 0), decode(0, f), b0, b1);
            end
            n_checks++;
            if (cap_tx[f - 1] !== 1'b1 || cap_tx[f] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap second start got %b%b exp 10", cap_tx[f - 1], cap_tx[f]);
            end
        end
    endtask

    task automatic test_ignore_busy(input int k);
        logic [7:0] b;
        bit ok;
        int f;
        f = frame_len(k);
        for (int n = 0; n < 2; n++) begin
            b = (n == 0) ? 8'hA5 : (8'($urandom) & 8'h7F);
            send_capture(k, b, 8'($urandom), f + 8, -1, 2 * cpb(k) + 1, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL ignore_accept dut%0d got no accept exp accept", k);
                continue;
            end
            for (int t = 0; t < f + 8; t++) begin
                n_checks++;
                if (cap_tx[t] !== exp_tx(k, b, 8'h00, 1, t) || cap_done[t] !== exp_done(k, 1, t) ||
                    cap_busy[t] !== exp_busy(k, 1, t)) begin
                    n_fail++;
                    $display("FAIL ignore dut%0d t=%0d tx/done/busy got %b%b%b exp %b%b%b", k, t,
                             cap_tx[t], cap_done[t], cap_busy[t], exp_tx(k, b, 8'h00, 1, t),
                             exp_done(k, 1, t), exp_busy(k, 1, t));
                end
            end
            n_checks++;
            if (decode(k, 0) !== b) begin
                n_fail++;
                $display("FAIL ignore_decode dut%0d got %02h exp %02h", k, decode(k, 0), b);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            reset_v[k] = 1'b1;
            valid_v[k] = 1'b0;
            data_v[k]  = 8'h00;
        end
        test_reset();
        test_a5_pattern(0);
        test_frames(0, 8'hA5, 8'h00);
        test_frames(1, 8'hA5, 8'h07);
        test_frames(2, 8'h00, 8'hFF);
        test_back_to_back();
        test_ignore_busy(0);
        test_a5_pattern(3);
        test_frames(3, 8'hA5, 8'h5A);
        test_ignore_busy(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
